// File: rtl/serial_sub.sv
// Bit-serial subtractor: DIFF = A - B - BIN, one bit per clock, LSB first.
// A single full-subtractor cell with a registered borrow, sequenced by an IDLE/SHIFT/DONE FSM.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             load;
  logic             shift_en;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;
  logic             last;
  logic             x, y, d, bn;

  assign last = (cnt == CW'(WIDTH - 1));

  // Full-subtractor cell on the current LSBs and the running borrow.
  assign x  = a_sh[0];
  assign y  = b_sh[0];
  assign d  = x ^ y ^ borrow;
  assign bn = (~x & y) | (~x & borrow) | (y & borrow);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values, like real hardware.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (load) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= bin;
      cnt    <= '0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
    end else if (shift_en) begin
      diff   <= {d, diff[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      borrow <= bn;
      cnt    <= cnt + CW'(1);
      // On the last bit, d is the result sign, which decides signed overflow.
      if (last) begin
        bout <= bn;
        ovf  <= (a_msb ^ b_msb) & (d ^ a_msb);
      end
    end
  end

endmodule
